// File: rtl/frame_buffer_ctrl.sv
// frame_buffer_ctrl: double-buffered pixel-pair store, sequential back-bank fill and
// random front-bank reads, with bank swaps only on scan-frame boundaries.
module frame_buffer_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 6,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_sof,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              scan_frame_done,
  output logic              front_sel,
  output logic              frame_full,
  output logic              overflow,
  output logic [7:0]        frame_count
);
  typedef enum logic {FILL, WAIT_SWAP} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] wptr, waddr;
  logic [DATA_W-1:0] mem [2*DEPTH];
  logic we, last, swap;
  always_ff @(posedge clk)
    if (!reset) state <= FILL;
    else state <= state_nxt;
  always_comb
    state_nxt = (state == FILL) ? (last ? WAIT_SWAP : FILL)
                                : (scan_frame_done ? FILL : WAIT_SWAP);
  always_comb begin
    wr_ready   = state == FILL;
    frame_full = state == WAIT_SWAP;
  end
  // A start-of-frame write lands at address 0 regardless of the current pointer.
  always_comb begin
    we    = wr_valid && wr_ready && reset;
    waddr = wr_sof ? '0 : wptr;
    last  = we && !wr_sof && wptr == ADDR_W'(DEPTH - 1);
    swap  = frame_full && scan_frame_done;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      wptr        <= '0;
      front_sel   <= 1'b0;
      frame_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (wr_ready) wptr <= wr_sof ? ADDR_W'(wr_valid) : wptr + ADDR_W'(wr_valid);
      front_sel   <= front_sel ^ swap;
      frame_count <= frame_count + 8'(swap);
      if (wr_ready && wr_sof) overflow <= 1'b0;
      else if (frame_full && wr_valid) overflow <= 1'b1;
    end
  always_ff @(posedge clk)
    if (we) mem[{~front_sel, waddr}] <= wr_data;
  always_ff @(posedge clk)
    if (!reset) rd_data <= '0;
    else rd_data <= mem[{front_sel, rd_addr}];
endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// tb_frame_buffer_ctrl: directed checks of fill, swap, overflow, restart and reset behaviour.
module tb_frame_buffer_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_sof = 1'b0;
  logic       wr_valid = 1'b0;
  logic [5:0] wr_data = '0;
  logic       wr_ready;
  logic [8:0] rd_addr = '0;
  logic [5:0] rd_data;
  logic       scan_frame_done = 1'b0;
  logic       front_sel;
  logic       frame_full;
  logic       overflow;
  logic [7:0] frame_count;
  int checks = 0;
  int failures = 0;
  frame_buffer_ctrl dut (
    .clk(clk), .reset(reset), .wr_sof(wr_sof), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_addr(rd_addr), .rd_data(rd_data),
    .scan_frame_done(scan_frame_done), .front_sel(front_sel), .frame_full(frame_full),
    .overflow(overflow), .frame_count(frame_count)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic fill(input int n, input int off);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = 6'(i + off);
      step();
    end
    wr_valid = 1'b0;
  endtask
  task automatic sfd();
    scan_frame_done = 1'b1;
    step();
    scan_frame_done = 1'b0;
  endtask
  task automatic rd(input int a, input int exp, input string tag);
    rd_addr = 9'(a);
    step();
    chk(tag, 32'(rd_data), exp);
  endtask
  initial begin
    step();
    step();
    chk("rst_front_sel", 32'(front_sel), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_frame_full", 32'(frame_full), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    reset = 1'b1;
    step();
    fill(511, 0);
    chk("full_before_last", 32'(frame_full), 0);
    chk("ready_before_last", 32'(wr_ready), 1);
    fill(1, 511);
    chk("full_after_last", 32'(frame_full), 1);
    chk("ready_after_last", 32'(wr_ready), 0);
    chk("no_swap_yet", 32'(front_sel), 0);
    sfd();
    chk("swap1_front_sel", 32'(front_sel), 1);
    chk("swap1_count", 32'(frame_count), 1);
    chk("swap1_full", 32'(frame_full), 0);
    rd(0, 'h00, "rd_a0");
    rd(37, 'h25, "rd_a37");
    rd(511, 'h3F, "rd_a511");
    fill(512, 1);
    chk("ovf_full", 32'(frame_full), 1);
    wr_valid = 1'b1;
    wr_data  = 6'h3F;
    step();
    step();
    step();
    wr_valid = 1'b0;
    chk("ovf_set", 32'(overflow), 1);
    wr_sof = 1'b1;
    step();
    wr_sof = 1'b0;
    chk("sof_in_wait_full", 32'(frame_full), 1);
    chk("sof_in_wait_ovf", 32'(overflow), 1);
    sfd();
    chk("swap2_front_sel", 32'(front_sel), 0);
    chk("swap2_count", 32'(frame_count), 2);
    chk("ovf_sticky", 32'(overflow), 1);
    rd(0, 'h01, "ovf_rd_a0");
    rd(2, 'h03, "ovf_rd_a2");
    wr_sof = 1'b1;
    step();
    wr_sof = 1'b0;
    chk("ovf_cleared", 32'(overflow), 0);
    fill(100, 10);
    wr_sof   = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 6'h2A;
    step();
    wr_sof   = 1'b0;
    wr_valid = 1'b0;
    fill(510, 20);
    chk("sof_511_not_full", 32'(frame_full), 0);
    fill(1, 0);
    chk("sof_512_full", 32'(frame_full), 1);
    sfd();
    chk("swap3_front_sel", 32'(front_sel), 1);
    chk("swap3_count", 32'(frame_count), 3);
    rd(0, 'h2A, "sof_rd_a0");
    rd(1, 'h14, "sof_rd_a1");
    fill(511, 0);
    wr_valid        = 1'b1;
    wr_data         = 6'h3F;
    scan_frame_done = 1'b1;
    step();
    wr_valid        = 1'b0;
    scan_frame_done = 1'b0;
    chk("bnd_no_swap", 32'(front_sel), 1);
    chk("bnd_full", 32'(frame_full), 1);
    chk("bnd_count", 32'(frame_count), 3);
    step();
    step();
    chk("bnd_still_no_swap", 32'(front_sel), 1);
    for (int k = 0; k < 5; k++) begin
      rd_addr         = 9'(10 + k);
      scan_frame_done = (k == 2);
      step();
      scan_frame_done = 1'b0;
      chk($sformatf("sweep_k%0d", k), 32'(rd_data), (k < 3) ? 29 + k : 10 + k);
      if (k == 2) begin
        chk("bnd_swap_front_sel", 32'(front_sel), 0);
        chk("bnd_swap_count", 32'(frame_count), 4);
        chk("bnd_swap_full", 32'(frame_full), 0);
      end
    end
    fill(512, 5);
    chk("mid_full", 32'(frame_full), 1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("mid_rst_full", 32'(frame_full), 0);
    chk("mid_rst_ready", 32'(wr_ready), 1);
    chk("mid_rst_front_sel", 32'(front_sel), 0);
    chk("mid_rst_count", 32'(frame_count), 0);
    fill(512, 3);
    sfd();
    chk("post_rst_front_sel", 32'(front_sel), 1);
    rd(0, 'h03, "post_rst_rd_a0");
    rd(4, 'h07, "post_rst_rd_a4");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/frame_buffer_ctrl.md
# frame_buffer_ctrl

Double-buffered frame-buffer controller between the SPI pixel-receive path and the RGB LED matrix scanner. It writes incoming 6-bit pixel pairs ({upper RGB, lower RGB}) sequentially into a back bank. It serves random-address reads from the front bank to the matrix driver. Banks swap only at a scan-frame boundary, so the display never shows a partially written frame.

## Interface
Parameters:
- ADDR_W, 9: pixel-pair address width ({row[3:0], col[4:0]}, 16 row pairs × 32 columns).
- DATA_W, 6: pixel-pair width ({RGB1[2:0], RGB2[2:0]}).
- DEPTH, 512: entries per bank; always 2**ADDR_W.

Ports:
- clk  in  1  system clock, single clock domain.
- reset  in  1  synchronous, active-low reset.
- wr_sof  in  1  start-of-frame pulse from the SPI side; restarts the fill.
- wr_valid  in  1  a pixel pair is presented on wr_data this cycle.
- wr_data  in  DATA_W  pixel pair to store.
- wr_ready  out  1  controller accepts writes (high in FILL).
- rd_addr  in  ADDR_W  read address from the matrix driver.
- rd_data  out  DATA_W  registered front-bank data, 1-cycle latency.
- scan_frame_done  in  1  one-cycle pulse from the matrix driver after the last row of a scan is latched.
- front_sel  out  1  bank currently displayed.
- frame_full  out  1  back bank complete, swap pending.
- overflow  out  1  sticky: a write was dropped.
- frame_count  out  8  completed swaps, wraps 255→0.

## Operation
- Storage: two banks of DEPTH×DATA_W, inferred synchronous RAM. The back bank is !front_sel.
- Write pointer wptr is ADDR_W bits. All sampling happens on the posedge of clk.
- State FILL:
  - wr_ready=1 and frame_full=0.
  - wr_valid: bank[!front_sel][wptr] ← wr_data, then wptr ← wptr+1.
  - Write accepted at wptr==DEPTH-1: go to WAIT_SWAP and set wptr ← 0.
  - wr_sof without wr_valid: wptr ← 0. The partial frame is discarded and overflow is cleared.
  - wr_sof with wr_valid in the same cycle: the data is written to address 0 and wptr ← 1. overflow is cleared.
  - scan_frame_done: no effect.
- State WAIT_SWAP:
  - wr_ready=0 and frame_full=1.
  - wr_valid: data dropped, overflow ← 1.
  - wr_sof: ignored. The pending frame is never cancelled.
  - scan_frame_done: front_sel ← !front_sel, frame_count ← frame_count+1, go to FILL.
- Reads run every cycle independent of state: rd_data ← bank[front_sel][rd_addr].
- Reset (reset==0 at a posedge):
  - State FILL, wptr 0, front_sel 0, frame_count 0, overflow 0, rd_data 0, frame_full 0, wr_ready 1.
  - RAM contents are not cleared.
  - A reset mid-fill or mid-WAIT_SWAP abandons the frame. The next fill targets bank 1.

## Timing
- Write: accepted on the edge where wr_valid && wr_ready. There is no backpressure other than wr_ready, which is a combinational decode of state.
- Completion: the last write at edge N makes frame_full=1 and wr_ready=0 from after edge N.
- Swap: decided only from the state at the start of the cycle.
  - If the last write and scan_frame_done fall on the same edge, there is no swap; the swap waits for the next scan_frame_done.
  - After the swap edge, front_sel is flipped. Reads sampled on the swap edge use the old bank. Reads sampled on the next edge use the new bank.
- Read latency: exactly 1 cycle. rd_data holds the value for the rd_addr presented on the previous edge.
- A swap followed immediately by wr_valid on the next edge is accepted; there is no bubble.
- Throughput: one write and one read per cycle, simultaneously, on different banks. No write-read collision is possible.

## Test plan
- Reset/idle:
  - Stimulus: hold reset=0 for 2 cycles, then release.
  - Required: front_sel=0, frame_count=0, wr_ready=1, frame_full=0, overflow=0, rd_data=0.
- Full frame and swap:
  - Stimulus: write 512 values data=addr[5:0] back-to-back, then pulse scan_frame_done.
  - Required: frame_full rises after write 512 and front_sel becomes 1. Reads of addr 0, 37 and 511 then return 0x00, 0x25 and 0x3F.
- Overflow:
  - Stimulus: in WAIT_SWAP, issue 3 writes of 0x3F, then pulse scan_frame_done.
  - Required: overflow=1, and the new front bank is unchanged by the dropped writes. After the swap, a wr_sof clears overflow.
- Start-of-frame restart:
  - Stimulus: write 100 pairs, assert wr_sof with wr_valid and data 0x2A, write 511 more, then swap.
  - Required: the swap happens only after the 512th post-sof write, and address 0 reads 0x2A.
- Swap boundary:
  - Stimulus: 512th write and scan_frame_done on the same edge.
  - Required: no swap. The swap happens on the next scan_frame_done and frame_count increments by exactly 1.
- Read continuity and mid-op reset:
  - Stimulus: sweep rd_addr every cycle across a swap.
  - Required: rd_data switches banks exactly one cycle after the swap edge.
  - Stimulus: assert reset in WAIT_SWAP.
  - Required: state FILL, front_sel=0, frame_full=0.
